acos_search: RTL

ACOS_SEARCH -- requirements
Module: acos_search

---
 rtl/acos_search.sv | 118 +++++++++++
 1 files changed

// File: rtl/acos_search.sv
// Iterative arccos: resolves angle bits MSB-first by querying an external cosine engine.
// Optional macro ACOS_EXACT_ENDPOINTS_EN returns +/-1.0 inputs directly without searching.
module acos_search #(
  parameter int ITERS = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cos_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] angle_out,
  output logic        cq_req,
  output logic [31:0] cq_angle,
  input  logic        cq_ack,
  input  logic [31:0] cq_val,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_REQ    = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [4:0]         K_LAST  = 5'(31 - ITERS);
  localparam logic signed [31:0] POS_ONE = 32'sh4000_0000;
  localparam logic signed [31:0] NEG_ONE = 32'shC000_0000;

  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic [31:0]        acc_q, acc_d;
  logic [4:0]         k_q, k_d;
  logic               err_q, err_d;
  logic [31:0]        trial;

  assign trial = acc_q | (32'd1 << k_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      k_q     <= 5'd30;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    k_d     = k_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = cos_in;
          acc_d   = '0;
          k_d     = 5'd30;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (x_q > POS_ONE || x_q < NEG_ONE) begin
          err_d   = 1'b1;
          state_d = S_DONE;
`ifdef ACOS_EXACT_ENDPOINTS_EN
        end else if (x_q == POS_ONE) begin
          acc_d   = 32'h0000_0000;
          state_d = S_DONE;
        end else if (x_q == NEG_ONE) begin
          acc_d   = 32'h8000_0000;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Keep the trial bit only if the angle is still small enough (cos >= x).
        if (cq_ack) begin
          if ($signed(cq_val) >= x_q) acc_d = trial;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q - 5'd1;
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign angle_out   = acc_q;
  assign cq_req      = (state_q == S_REQ);
  assign cq_angle    = cq_req ? trial : 32'd0;
  assign dbg_state_o = state_q;

endmodule
